zpu_io_arbiter: RTL and testbench
=================================

// Module: zpu_io_arbiter
// PURPOSE
//  Round-robin arbiter sharing one external IO/memory bus between NREQ requesters (port 0 = ZPU core IO port,
//  others = DMA/debug masters). Latches single-cycle read/write strobes, sequences one bus transaction at a time,
//  and returns completion with the core's busy protocol. A watchdog terminates hung transactions.
// PARAMETERS
//  NREQ      2             number of requesters (2..4)
//  ADDR_W    32            address width; equals maxaddrbitincio+1
//  WORD_W    32            data width; equals wordSize
//  TIMEOUT   255           max WAIT cycles before forced completion; 0 disables watchdog
//  TO_DATA   32'hDEADBEEF  read data returned on timeout
// PORTS
//  clk          in   1             clock
//  areset       in   1             reset, synchronous, active-high
//  req_re       in   NREQ          per-port read strobe, 1 cycle
//  req_we       in   NREQ          per-port write strobe, 1 cycle
//  req_addr     in   NREQ*ADDR_W   per-port address, port i at [i*ADDR_W +: ADDR_W], valid with strobe
//  req_wdata    in   NREQ*WORD_W   per-port write data, valid with strobe
//  req_busy     out  NREQ          per-port busy; low exactly one cycle = transaction done
//  req_rdata    out  WORD_W        read data, valid in the cycle the granted port's busy is low
//  ext_re       out  1             external read strobe
//  ext_we       out  1             external write strobe
//  ext_addr     out  ADDR_W        external address
//  ext_wdata    out  WORD_W        external write data
//  ext_rdata    in   WORD_W        external read data, valid when ext_busy low in WAIT
//  ext_busy     in   1             external busy; first sampled in the cycle after the strobe
//  grant_id     out  2             port index of the current/last transaction
//  err_timeout  out  1             sticky: watchdog fired
//  err_overrun  out  1             sticky: strobe received on a port with a pending request
//  err_clr      in   1             clears both sticky errors (set in the same cycle wins)
// BEHAVIOUR
//  Reset: FSM=IDLE, pending=0, rr pointer=NREQ-1, req_busy=all 1, req_rdata=0, ext_re=ext_we=0,
//   ext_addr=ext_wdata=0, grant_id=0, errors=0. Reset mid-transaction aborts: no completion pulse.
//  Capture: strobe on port i with pending[i]=0 -> pending[i]=1, latch addr/wdata/is_write (we wins over re).
//   Strobe with pending[i]=1 -> ignored, err_overrun=1. All ports capture independently in the same cycle.
//  FSM IDLE  : any pending -> grant first pending port after rr pointer (wrap at NREQ-1->0), rr ptr=grant,
//              grant_id=grant -> ISSUE.
//  FSM ISSUE : ext_we (write) or ext_re (read) high this cycle only; ext_addr/ext_wdata from latch; timer=0 -> WAIT.
//  FSM WAIT  : ext_busy=0 -> capture ext_rdata (write: req_rdata unchanged) -> DONE.
//              else if TIMEOUT!=0 and timer==TIMEOUT-1 -> req_rdata=TO_DATA, err_timeout=1 -> DONE. else timer++.
//  FSM DONE  : req_busy[grant]=0 this cycle only; pending[grant]=0 -> IDLE. A new strobe on the granted port
//              in DONE is captured (not an overrun).
//  req_busy[i]=1 in every other cycle, incl. idle. Min latency: strobe cycle N -> busy low cycle N+4.
//  Fairness: with all ports pending continuously, each port completes once per NREQ transactions.
//  ext_addr/ext_wdata hold value after ISSUE until next ISSUE. Timer width $clog2(TIMEOUT+1), saturating.
// STRUCTURE
//  Widths come from zpu_config.v (wordSize, maxaddrbitincio); FSM state encodings local parameters
//  (State_Idle/Issue/Wait/Done). One sub-module: zpu_rr_pick (combinational NREQ-way round-robin picker,
//  inputs pending+pointer, outputs grant index+valid). Registered outputs only; no combinational path
//  from req_* to ext_*.
// TESTING
//  1 read: port0 re, addr=0x8000_0004; ext_busy low 2nd WAIT cycle, ext_rdata=0x1234_5678
//     -> ext_re once at N+2, req_busy[0] low at N+5 with req_rdata=0x1234_5678.
//  2 simultaneous: port0 we, port1 re same cycle, rr ptr=1 -> port0 write served first, then port1;
//     busy pulses in that order; grant_id 0 then 1.
//  3 timeout: TIMEOUT=4, ext_busy stuck 1 -> busy low after 4 WAIT cycles, req_rdata=0xDEADBEEF,
//     err_timeout=1 until err_clr.
//  4 overrun: port1 re twice while pending -> one transaction only, err_overrun=1, original addr used.
//  5 reset mid-WAIT: areset for 1 cycle -> no busy pulse, pending cleared, ext strobes 0; next request normal.
//  6 fairness: ports 0,1 re-strobe in every DONE cycle for 10 transactions -> grants alternate 0,1,0,1...

Source files
------------

// File: rtl/zpu_io_arbiter_pkg.sv
// Shared widths, state encoding and helpers for the ZPU IO/memory bus arbiter.
package zpu_io_arbiter_pkg;

    // Core configuration: word size and highest IO-inclusive address bit.
    localparam int WORD_SIZE           = 32;
    localparam int MAX_ADDR_BIT_INC_IO = 31;

    // grant_id is always two bits wide (up to four requesters).
    localparam int GID_W = 2;

    typedef enum logic [1:0] {
        State_Idle  = 2'd0,
        State_Issue = 2'd1,
        State_Wait  = 2'd2,
        State_Done  = 2'd3
    } state_t;

    // Width of an internal port index for n requesters (n in 2..4).
    function automatic int idx_w(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/zpu_io_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending port strictly after the pointer, wrapping.
module zpu_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] pending_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   grant_o,
    output logic            valid_o
);

    // Scan from the farthest offset down so the nearest pending port after the pointer is written last.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (pending_i[(int'(ptr_i) + k) % NREQ]) begin
                grant_o = IW'((int'(ptr_i) + k) % NREQ);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zpu_io_arbiter.sv
// Round-robin arbiter sharing one external IO bus between NREQ strobe-based requesters,
// with per-port request latches, one-at-a-time bus sequencing and a WAIT watchdog.
module zpu_io_arbiter
    import zpu_io_arbiter_pkg::*;
#(
    parameter int                NREQ    = 2,
    parameter int                ADDR_W  = MAX_ADDR_BIT_INC_IO + 1,
    parameter int                WORD_W  = WORD_SIZE,
    parameter int                TIMEOUT = 255,
    parameter logic [WORD_W-1:0] TO_DATA = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic [NREQ-1:0]          req_re,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*WORD_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_busy,
    output logic [WORD_W-1:0]        req_rdata,
    output logic                     ext_re,
    output logic                     ext_we,
    output logic [ADDR_W-1:0]        ext_addr,
    output logic [WORD_W-1:0]        ext_wdata,
    input  logic [WORD_W-1:0]        ext_rdata,
    input  logic                     ext_busy,
    output logic [GID_W-1:0]         grant_id,
    output logic                     err_timeout,
    output logic                     err_overrun,
    input  logic                     err_clr
);

    localparam int IW = idx_w(NREQ);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                         state_q, state_d;
    logic [NREQ-1:0]                pend_q, pend_d;
    logic [NREQ-1:0]                wr_q, wr_d;
    logic [NREQ-1:0][ADDR_W-1:0]    addr_q, addr_d;
    logic [NREQ-1:0][WORD_W-1:0]    wdat_q, wdat_d;
    logic [IW-1:0]                  rr_q, rr_d;
    logic [GID_W-1:0]               gid_q, gid_d;
    logic [TW-1:0]                  timer_q, timer_d;
    logic [NREQ-1:0]                busy_q, busy_d;
    logic [WORD_W-1:0]              rdata_q, rdata_d;
    logic                           ext_re_q, ext_re_d, ext_we_q, ext_we_d;
    logic [ADDR_W-1:0]              ext_addr_q, ext_addr_d;
    logic [WORD_W-1:0]              ext_wdata_q, ext_wdata_d;
    logic                           eto_q, eto_d, eov_q, eov_d;

    logic [IW-1:0] pick;
    logic          pick_vld;
    logic [IW-1:0] gsel;
    logic          timeout_hit;

    assign gsel        = gid_q[IW-1:0];
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TO_LAST);

    zpu_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .pending_i (pend_q),
        .ptr_i     (rr_q),
        .grant_o   (pick),
        .valid_o   (pick_vld)
    );

    // State and datapath registers; reset aborts any transaction without a completion pulse.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q     <= State_Idle;
            pend_q      <= '0;
            wr_q        <= '0;
            addr_q      <= '0;
            wdat_q      <= '0;
            rr_q        <= IW'(NREQ - 1);
            gid_q       <= '0;
            timer_q     <= '0;
            busy_q      <= '1;
            rdata_q     <= '0;
            ext_re_q    <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            eto_q       <= 1'b0;
            eov_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            rr_q        <= rr_d;
            gid_q       <= gid_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            rdata_q     <= rdata_d;
            ext_re_q    <= ext_re_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            eto_q       <= eto_d;
            eov_q       <= eov_d;
        end
    end

    // Next-state: IDLE -> ISSUE -> WAIT (until ext done or watchdog) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            State_Idle:  if (pick_vld) state_d = State_Issue;
            State_Issue: state_d = State_Wait;
            State_Wait:  if (!ext_busy || timeout_hit) state_d = State_Done;
            State_Done:  state_d = State_Idle;
            default:     state_d = State_Idle;
        endcase
    end

    // Request capture plus next values of every registered output, one cycle ahead of the state they belong to.
    always_comb begin
        pend_d      = pend_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        rr_d        = rr_q;
        gid_d       = gid_q;
        timer_d     = timer_q;
        busy_d      = '1;
        rdata_d     = rdata_q;
        ext_re_d    = 1'b0;
        ext_we_d    = 1'b0;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        eto_d       = eto_q & ~err_clr;
        eov_d       = eov_q & ~err_clr;

        // Completion frees the granted slot first, so a strobe in DONE re-arms it rather than overrunning.
        for (int i = 0; i < NREQ; i++) begin
            if (state_q == State_Done && gsel == IW'(i)) pend_d[i] = 1'b0;
            if (req_re[i] || req_we[i]) begin
                if (pend_d[i]) begin
                    eov_d = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    wr_d[i]   = req_we[i];
                    addr_d[i] = req_addr[i*ADDR_W +: ADDR_W];
                    wdat_d[i] = req_wdata[i*WORD_W +: WORD_W];
                end
            end
        end

        unique case (state_q)
            State_Idle: begin
                if (pick_vld) begin
                    rr_d        = pick;
                    gid_d       = GID_W'(pick);
                    ext_we_d    = wr_q[pick];
                    ext_re_d    = ~wr_q[pick];
                    ext_addr_d  = addr_q[pick];
                    ext_wdata_d = wdat_q[pick];
                end
            end
            State_Issue: timer_d = '0;
            State_Wait: begin
                if (!ext_busy) begin
                    if (!wr_q[gsel]) rdata_d = ext_rdata;
                    busy_d[gsel] = 1'b0;
                end else if (timeout_hit) begin
                    rdata_d      = TO_DATA;
                    eto_d        = 1'b1;
                    busy_d[gsel] = 1'b0;
                end else if (timer_q != {TW{1'b1}}) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: ;
        endcase
    end

    assign req_busy    = busy_q;
    assign req_rdata   = rdata_q;
    assign ext_re      = ext_re_q;
    assign ext_we      = ext_we_q;
    assign ext_addr    = ext_addr_q;
    assign ext_wdata   = ext_wdata_q;
    assign grant_id    = gid_q;
    assign err_timeout = eto_q;
    assign err_overrun = eov_q;

endmodule

// File: tb/tb_zpu_io_arbiter.sv
// Directed bench for zpu_io_arbiter: single-transaction vector table plus multi-cycle sequences.
module tb_zpu_io_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int WW   = 32;
    localparam int TO   = 4;

    logic              clk = 1'b0;
    logic              areset;
    logic [NREQ-1:0]   req_re, req_we, req_busy;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*WW-1:0] req_wdata;
    logic [WW-1:0]     req_rdata, ext_wdata, ext_rdata;
    logic              ext_re, ext_we, ext_busy;
    logic [AW-1:0]     ext_addr;
    logic [1:0]        grant_id;
    logic              err_timeout, err_overrun, err_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    zpu_io_arbiter #(
        .NREQ(NREQ), .ADDR_W(AW), .WORD_W(WW), .TIMEOUT(TO), .TO_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk), .areset(areset),
        .req_re(req_re), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_busy(req_busy), .req_rdata(req_rdata),
        .ext_re(ext_re), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_busy(ext_busy),
        .grant_id(grant_id), .err_timeout(err_timeout), .err_overrun(err_overrun), .err_clr(err_clr)
    );

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] xrdata;     // ext_rdata presented when ext_busy drops
        int          bc;         // WAIT cycles with ext_busy high before it drops
        int          exp_done;   // cycle (after strobe) in which req_busy[port] is low
        logic [31:0] exp_rdata;
        bit          exp_to;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_re  = '0;
        req_we  = '0;
        err_clr = 1'b0;
    endtask

    task automatic strobe(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (wr) req_we[p] = 1'b1;
        else    req_re[p] = 1'b1;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*WW +: WW] = d;
    endtask

    // One isolated transaction; observes every cycle for 12 cycles after the strobe.
    task automatic run_vec(input vec_t v, input string tag);
        int done_at = -1, stb_at = -1, nstb = 0, nbusy = 0;
        logic [31:0] rd = '0, sa = '0, swd = '0;
        logic [1:0]  gid = '0, bsel = '1;
        bit skind = 1'b0;
        tick();
        idle_in();
        strobe(v.port, v.wr, v.addr, v.wdata);
        ext_busy = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            idle_in();
            ext_busy  = (c == 3 + v.bc) ? 1'b0 : 1'b1;
            ext_rdata = (c == 3 + v.bc) ? v.xrdata : 32'hBAD0_BAD0;
            if (ext_re || ext_we) begin
                nstb++; stb_at = c; sa = ext_addr; swd = ext_wdata; skind = ext_we;
            end
            if (req_busy != 2'b11) begin
                nbusy++; done_at = c; rd = req_rdata; gid = grant_id; bsel = req_busy;
            end
        end
        chk({tag, ".strobe_cycle"}, stb_at, 2);
        chk({tag, ".strobe_count"}, nstb, 1);
        chk({tag, ".strobe_kind"}, skind, v.wr);
        chk({tag, ".ext_addr"}, sa, v.addr);
        if (v.wr) chk({tag, ".ext_wdata"}, swd, v.wdata);
        chk({tag, ".done_cycle"}, done_at, v.exp_done);
        chk({tag, ".done_count"}, nbusy, 1);
        chk({tag, ".busy_port"}, bsel, (v.port == 0) ? 2'b10 : 2'b01);
        chk({tag, ".rdata"}, rd, v.exp_rdata);
        chk({tag, ".grant_id"}, gid, v.port);
        chk({tag, ".err_timeout"}, err_timeout, v.exp_to);
    endtask

    initial begin
        int d0, d1, nstb, nbusy, ndone;
        logic [1:0]  g0, g1;
        logic [31:0] sa, rd;
        bit k0, k1, bad;
        logic [1:0] gseq[10];
        vec_t nv;

        //        port wr addr          wdata         xrdata        bc  done rdata         to
        vt[0] = '{0, 0, 32'h8000_0004, 32'h0,        32'h1234_5678, 1,  5, 32'h1234_5678, 0};
        vt[1] = '{1, 1, 32'h0000_0010, 32'hA5A5_0001, 32'h0,       0,  4, 32'h1234_5678, 0};
        vt[2] = '{1, 0, 32'h0000_0FFC, 32'h0,        32'hCAFE_F00D, 3,  7, 32'hCAFE_F00D, 0};
        vt[3] = '{0, 0, 32'h0000_0100, 32'h0,        32'h0,        99, 7, 32'hDEAD_BEEF, 1};
        vt[4] = '{1, 1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0,       0,  4, 32'hDEAD_BEEF, 1};

        areset = 1'b1; idle_in(); ext_busy = 1'b1; ext_rdata = '0;
        req_addr = '0; req_wdata = '0;
        tick(); tick(); tick();
        areset = 1'b0;
        tick();
        chk("rst.req_busy", req_busy, 2'b11);
        chk("rst.req_rdata", req_rdata, 0);
        chk("rst.ext_strobes", {ext_re, ext_we}, 2'b00);
        chk("rst.ext_addr", ext_addr, 0);
        chk("rst.ext_wdata", ext_wdata, 0);
        chk("rst.grant_id", grant_id, 0);
        chk("rst.errors", {err_timeout, err_overrun}, 2'b00);

        for (int v = 0; v < 5; v++) run_vec(vt[v], $sformatf("vec%0d", v));

        // Sticky timeout cleared by err_clr.
        err_clr = 1'b1;
        tick();
        idle_in();
        chk("errclr.err_timeout", err_timeout, 0);

        // Simultaneous write on port 0 and read on port 1 with pointer at 1.
        tick();
        strobe(0, 1, 32'h40, 32'h1111_2222);
        strobe(1, 0, 32'h44, 32'h0);
        ext_busy = 1'b0; ext_rdata = 32'h5555_AAAA;
        d0 = -1; d1 = -1; g0 = '1; g1 = '1; k0 = 0; k1 = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            idle_in();
            if (c == 2) k0 = ext_we;
            if (c == 6) k1 = ext_re;
            if (!req_busy[0] && d0 < 0) begin d0 = c; g0 = grant_id; end
            if (!req_busy[1] && d1 < 0) begin d1 = c; g1 = grant_id; rd = req_rdata; end
        end
        chk("simul.p0_done", d0, 4);
        chk("simul.p0_grant", g0, 0);
        chk("simul.p0_is_write", k0, 1);
        chk("simul.p1_done", d1, 8);
        chk("simul.p1_grant", g1, 1);
        chk("simul.p1_is_read", k1, 1);
        chk("simul.p1_rdata", rd, 32'h5555_AAAA);

        // Overrun: port 1 re-strobed twice while pending; set beats a same-cycle clear.
        chk("ovr.before", err_overrun, 0);
        tick();
        strobe(1, 0, 32'h100, 32'h0);
        ext_busy = 1'b1; ext_rdata = 32'h7777_0000;
        nstb = 0; nbusy = 0; sa = '0; d1 = -1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            idle_in();
            ext_busy = (c == 4) ? 1'b0 : 1'b1;
            if (c == 1) begin strobe(1, 0, 32'h200, 32'h0); err_clr = 1'b1; end
            if (c == 2) begin
                strobe(1, 0, 32'h300, 32'h0);
                chk("ovr.set_wins_clr", err_overrun, 1);
            end
            if (ext_re || ext_we) begin nstb++; sa = ext_addr; end
            if (!req_busy[1]) begin nbusy++; d1 = c; rd = req_rdata; end
        end
        chk("ovr.strobe_count", nstb, 1);
        chk("ovr.orig_addr", sa, 32'h100);
        chk("ovr.done_count", nbusy, 1);
        chk("ovr.done_cycle", d1, 5);
        chk("ovr.rdata", rd, 32'h7777_0000);
        chk("ovr.sticky", err_overrun, 1);
        err_clr = 1'b1;
        tick();
        idle_in();
        chk("ovr.cleared", err_overrun, 0);

        // Reset during WAIT aborts with no completion pulse.
        tick();
        strobe(0, 0, 32'h500, 32'h0);
        ext_busy = 1'b1;
        nbusy = 0; nstb = 0; bad = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            idle_in();
            areset = (c == 4);
            if (req_busy != 2'b11) nbusy++;
            if (c >= 5) begin
                if (ext_re || ext_we) nstb++;
                if (c == 5 && (req_rdata != 0 || grant_id != 0)) bad = 1;
            end
        end
        chk("rstmid.no_done", nbusy, 0);
        chk("rstmid.no_strobe", nstb, 0);
        chk("rstmid.regs_cleared", bad, 0);
        nv = '{0, 0, 32'h600, 32'h0, 32'h0600_0600, 0, 4, 32'h0600_0600, 0};
        run_vec(nv, "rstmid.next");

        // Fairness: both ports re-strobe in their DONE cycle; grants must alternate.
        tick();
        strobe(0, 0, 32'h700, 32'h0);
        strobe(1, 0, 32'h704, 32'h0);
        ext_busy = 1'b0; ext_rdata = 32'h0;
        ndone = 0;
        for (int c = 1; c <= 80 && ndone < 10; c++) begin
            tick();
            idle_in();
            for (int p = 0; p < NREQ; p++) begin
                if (!req_busy[p] && ndone < 10) begin
                    gseq[ndone] = grant_id;
                    ndone++;
                    strobe(p, 0, 32'h700 + 32'(p*4), 32'h0);
                end
            end
        end
        chk("fair.count", ndone, 10);
        for (int k = 0; k < 10; k++)
            if (k < ndone) chk($sformatf("fair.grant%0d", k), gseq[k], (k % 2 == 0) ? 2'd1 : 2'd0);
        chk("fair.no_overrun", err_overrun, 0);
        for (int c = 0; c < 12; c++) begin tick(); idle_in(); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
